wb_dmem_ctrl: RTL and testbench
===============================

// Module: wb_dmem_ctrl
// PURPOSE
//  Parametrised Wishbone classic-cycle data memory; successor to the single-cycle dmem slave.
//  Registered read path and a one-wait-state ack FSM. Out-of-range error termination,
//  configurable depth and base address, optional per-byte parity.
//  Sits on the core data bus behind the interconnect, one slave port.
// PARAMETERS
//  DEPTH      1024           number of 32-bit words (power of 2, >=16)
//  BASE_ADDR  32'h0000_0000  byte base; must be aligned to DEPTH*4
//  AW         $clog2(DEPTH)  derived word-address width, not overridable
// PORTS
//  clk_i   in   1   clock, all logic on rising edge
//  rst_i   in   1   reset, asynchronous, active-high
//  cyc_i   in   1   Wishbone cycle
//  stb_i   in   1   Wishbone strobe
//  adr_i   in   32  byte address; [1:0] ignored
//  we_i    in   1   1=write, 0=read
//  sel_i   in   4   byte lane enables, sel_i[n] -> dat_i[8n+7:8n]
//  dat_i   in   32  write data
//  dat_o   out  32  read data, registered
//  ack_o   out  1   normal termination, registered
//  err_o   out  1   error termination, registered
// BEHAVIOUR
//  Reset: state=IDLE, ack_o=0, err_o=0, dat_o=0. Memory array is not reset (contents X).
//  Request: req = cyc_i & stb_i & (state==IDLE).
//  Range check: in_rng = (adr_i[31:AW+2] == BASE_ADDR[31:AW+2]); word index = adr_i[AW+1:2].
//  FSM states: IDLE, RESP.
//  IDLE -> RESP on req; otherwise stay in IDLE.
//  RESP -> IDLE always after one cycle; one termination pulse per request.
//  Edge that samples req, by case:
//   - in_rng & we_i: lanes with sel_i=1 are written; others are unchanged.
//   - in_rng & ~we_i: dat_o <= mem[word]; full word, sel_i ignored.
//   - ~in_rng: no write, dat_o unchanged.
//  In RESP:
//   - in_rng request: ack_o=1, err_o=0.
//   - ~in_rng request: err_o=1, ack_o=0.
//   - ack_o and err_o are never high together.
//  Latency: termination one cycle after req is sampled. Max throughput is 1 transfer per 2 cycles.
//   Back-to-back requests are accepted in the IDLE cycle after RESP.
//  dat_o holds its value until the next accepted in-range read; it is valid while ack_o=1.
//  Write with sel_i=4'b0000: acked, memory unchanged.
//  Abort: if cyc_i=0 during RESP, ack_o/err_o are still driven that cycle; a write is already committed.
//   Master ignores the pulse.
//  Reset asserted mid-transfer: immediate return to IDLE, outputs cleared.
//   A write sampled before reset is kept.
//  Same-address read after write: the read returns the new data (write committed two edges earlier).
// CONFIGURATION
//  WB_DMEM_PARITY_EN defined:
//   - A 4-bit even-parity array runs alongside memory; p[n] = ^byte[n].
//   - On write, p[n] is updated for each lane with sel_i[n]=1.
//   - On an in-range read, any mismatch on a lane with sel_i[n]=1 gives err_o=1 instead of ack_o.
//     dat_o is still loaded.
//  WB_DMEM_PARITY_EN undefined:
//   - No parity storage.
//   - err_o is raised only for out-of-range addresses.
// TESTING
//  Reset while idle:
//   rst_i=1 async -> dat_o=0, ack_o=0, err_o=0 immediately, without waiting for a clock edge.
//  Word write then read:
//   - write adr=BASE+0x10, dat=32'hDEAD_BEEF, sel=4'hF -> ack_o one cycle later.
//   - read of same address -> dat_o=32'hDEAD_BEEF with ack_o.
//  Byte lanes:
//   - after the word write above, write sel=4'b0100, dat=32'h0055_0000 -> ack.
//   - read -> 32'hDE55_BEEF.
//  Out of range:
//   - read adr=BASE+DEPTH*4 -> err_o=1, ack_o=0, dat_o unchanged.
//   - write to same address -> err_o=1, memory unchanged (verify by readback).
//  Back-to-back and top word:
//   - 4 consecutive writes at word DEPTH-4..DEPTH-1, stb held -> one ack every 2nd cycle.
//   - readback matches.
//  Parity (WB_DMEM_PARITY_EN):
//   - write 32'h0000_0001; bench flips stored bit 0 hierarchically.
//   - read sel=4'hF -> err_o=1.
//   - same read with sel=4'hE -> ack_o=1.

Source files
------------

// File: rtl/wb_dmem_ctrl.sv
// Wishbone classic-cycle data memory slave with one wait state and a registered read path.
// Optional per-lane even parity checking is built when WB_DMEM_PARITY_EN is defined.
module wb_dmem_ctrl #(
  parameter int unsigned DEPTH     = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cyc_i,
  input  logic        stb_i,
  input  logic [31:0] adr_i,
  input  logic        we_i,
  input  logic [3:0]  sel_i,
  input  logic [31:0] dat_i,
  output logic [31:0] dat_o,
  output logic        ack_o,
  output logic        err_o
);
  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic {IDLE = 1'b0, RESP = 1'b1} state_t;

  // Handshake: a request is cyc_i & stb_i seen at a rising edge while IDLE.
  // Exactly one of ack_o/err_o pulses for one cycle after that edge.
  // Requests are not accepted during RESP, so a held strobe is taken again
  // in the IDLE cycle that follows.
  state_t      state_q, state_d;
  logic        ack_q, ack_d;
  logic        err_q, err_d;
  logic [31:0] dat_q, dat_d;

  logic [31:0] mem [DEPTH];

  logic          req;
  logic          in_rng;
  logic          wr_en;
  logic [AW-1:0] word;
  logic [31:0]   rd_word;
  logic          par_err;
  logic          unused_adr;

  assign req        = cyc_i & stb_i & (state_q == IDLE);
  assign in_rng     = (adr_i[31:AW+2] == BASE_ADDR[31:AW+2]);
  assign word       = adr_i[AW+1:2];
  assign rd_word    = mem[word];
  assign wr_en      = req & in_rng & we_i;
  assign unused_adr = ^adr_i[1:0];

`ifdef WB_DMEM_PARITY_EN
  logic [3:0] par_mem [DEPTH];
  logic [3:0] par_rd;

  assign par_rd = par_mem[word];

  // Only lanes the master selects can flag a parity fault.
  always_comb begin
    par_err = 1'b0;
    for (int n = 0; n < 4; n++) begin
      if (sel_i[n] && ((^rd_word[8*n +: 8]) != par_rd[n])) par_err = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      for (int n = 0; n < 4; n++) begin
        if (sel_i[n]) par_mem[word][n] <= ^dat_i[8*n +: 8];
      end
    end
  end
`else
  assign par_err = 1'b0;
`endif

  // Storage is deliberately not reset; a write sampled before reset survives it.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      for (int n = 0; n < 4; n++) begin
        if (sel_i[n]) mem[word][8*n +: 8] <= dat_i[8*n +: 8];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    dat_d   = dat_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          state_d = RESP;
          if (!in_rng) begin
            err_d = 1'b1;
          end else begin
            if (!we_i) dat_d = rd_word;
            if (!we_i && par_err) err_d = 1'b1;
            else                  ack_d = 1'b1;
          end
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      dat_q   <= 32'h0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      dat_q   <= dat_d;
    end
  end

  assign dat_o = dat_q;
  assign ack_o = ack_q;
  assign err_o = err_q;

endmodule

// File: tb/tb_wb_dmem_ctrl.sv
// Bench for wb_dmem_ctrl: directed scenarios plus randomized traffic against a word-array model.
// Parity scenario is compiled in when WB_DMEM_PARITY_EN is defined.
module tb_wb_dmem_ctrl;
  localparam int unsigned DEPTH = 64;
  localparam logic [31:0] BASE  = 32'h0001_0000;
  localparam logic [31:0] LIMIT = BASE + DEPTH * 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cyc = 1'b0;
  logic        stb = 1'b0;
  logic [31:0] adr = 32'h0;
  logic        we  = 1'b0;
  logic [3:0]  sel = 4'h0;
  logic [31:0] dat_w = 32'h0;
  logic [31:0] dat_r;
  logic        ack;
  logic        err;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [31:0] ref_mem [DEPTH];
  logic [31:0] model_dat;
  logic [31:0] exp_q[$];

  wb_dmem_ctrl #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
    .clk_i(clk), .rst_i(rst), .cyc_i(cyc), .stb_i(stb), .adr_i(adr), .we_i(we),
    .sel_i(sel), .dat_i(dat_w), .dat_o(dat_r), .ack_o(ack), .err_o(err)
  );

  always #5 clk = ~clk;

  function automatic bit model_in_rng(input logic [31:0] a);
    return (a >= BASE) && (a < LIMIT);
  endfunction

  function automatic int model_idx(input logic [31:0] a);
    return int'((a - BASE) / 4);
  endfunction

  task automatic model_write(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
    int idx;
    idx = model_idx(a);
    for (int n = 0; n < 4; n++) if (s[n]) ref_mem[idx][8*n +: 8] = d[8*n +: 8];
  endtask

  // Single transfer; returns the terminating outputs and cycles waited.
  task automatic do_xfer(input logic w, input logic [31:0] a, input logic [3:0] s,
                         input logic [31:0] d, output logic g_ack, output logic g_err,
                         output logic [31:0] g_dat, output int lat);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; sel = s; dat_w = d;
    lat = 0;
    do begin
      @(posedge clk); #1; lat++;
    end while (!(ack || err) && lat < 8);
    g_ack = ack; g_err = err; g_dat = dat_r;
    @(negedge clk);
    cyc = 1'b0; stb = 1'b0;
  endtask

  task automatic test_reset;
    #2;
    n_cmp++; if (dat_r !== 32'h0) begin n_fail++; $display("FAIL reset_dat got=%h exp=0", dat_r); end
    n_cmp++; if (ack !== 1'b0) begin n_fail++; $display("FAIL reset_ack got=%b exp=0", ack); end
    n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err got=%b exp=0", err); end
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    model_dat = 32'h0;
  endtask

  task automatic test_word_rw;
    logic a, e; logic [31:0] d; int lat;
    do_xfer(1'b1, BASE + 32'h10, 4'hF, 32'hDEAD_BEEF, a, e, d, lat);
    model_write(BASE + 32'h10, 4'hF, 32'hDEAD_BEEF);
    n_cmp++; if (a !== 1'b1 || e !== 1'b0) begin n_fail++; $display("FAIL wr_term ack=%b err=%b exp ack=1 err=0", a, e); end
    n_cmp++; if (lat != 1) begin n_fail++; $display("FAIL wr_latency got=%0d exp=1", lat); end
    do_xfer(1'b0, BASE + 32'h10, 4'hF, 32'h0, a, e, d, lat);
    model_dat = ref_mem[4];
    n_cmp++; if (a !== 1'b1 || e !== 1'b0) begin n_fail++; $display("FAIL rd_term ack=%b err=%b exp ack=1 err=0", a, e); end
    n_cmp++; if (d !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL rd_data got=%h exp=deadbeef", d); end
    n_cmp++; if (lat != 1) begin n_fail++; $display("FAIL rd_latency got=%0d exp=1", lat); end
  endtask

  task automatic test_byte_lanes;
    logic a, e; logic [31:0] d; int lat;
    do_xfer(1'b1, BASE + 32'h10, 4'b0100, 32'h0055_0000, a, e, d, lat);
    model_write(BASE + 32'h10, 4'b0100, 32'h0055_0000);
    n_cmp++; if (a !== 1'b1 || e !== 1'b0) begin n_fail++; $display("FAIL lane_wr ack=%b err=%b exp ack=1 err=0", a, e); end
    do_xfer(1'b0, BASE + 32'h10, 4'h0, 32'h0, a, e, d, lat);
    model_dat = ref_mem[4];
    n_cmp++; if (d !== 32'hDE55_BEEF || a !== 1'b1) begin n_fail++; $display("FAIL lane_rd got=%h ack=%b exp=de55beef ack=1", d, a); end
    do_xfer(1'b1, BASE + 32'h10, 4'h0, 32'h1234_5678, a, e, d, lat);
    n_cmp++; if (a !== 1'b1 || e !== 1'b0) begin n_fail++; $display("FAIL sel0_wr ack=%b err=%b exp ack=1 err=0", a, e); end
    do_xfer(1'b0, BASE + 32'h10, 4'hF, 32'h0, a, e, d, lat);
    n_cmp++; if (d !== ref_mem[4]) begin n_fail++; $display("FAIL sel0_rd got=%h exp=%h", d, ref_mem[4]); end
  endtask

  task automatic test_out_of_range;
    logic a, e; logic [31:0] d; int lat;
    do_xfer(1'b1, BASE, 4'hF, 32'hA5A5_5A5A, a, e, d, lat);
    model_write(BASE, 4'hF, 32'hA5A5_5A5A);
    do_xfer(1'b0, LIMIT, 4'hF, 32'h0, a, e, d, lat);
    n_cmp++; if (e !== 1'b1 || a !== 1'b0) begin n_fail++; $display("FAIL oor_rd_term ack=%b err=%b exp ack=0 err=1", a, e); end
    n_cmp++; if (d !== model_dat) begin n_fail++; $display("FAIL oor_rd_dat got=%h exp=%h", d, model_dat); end
    n_cmp++; if (lat != 1) begin n_fail++; $display("FAIL oor_latency got=%0d exp=1", lat); end
    do_xfer(1'b1, LIMIT, 4'hF, 32'h0BAD_0BAD, a, e, d, lat);
    n_cmp++; if (e !== 1'b1 || a !== 1'b0) begin n_fail++; $display("FAIL oor_wr_term ack=%b err=%b exp ack=0 err=1", a, e); end
    do_xfer(1'b1, BASE - 32'h4, 4'hF, 32'h0BAD_0BAD, a, e, d, lat);
    n_cmp++; if (e !== 1'b1 || a !== 1'b0) begin n_fail++; $display("FAIL below_wr_term ack=%b err=%b exp ack=0 err=1", a, e); end
    do_xfer(1'b0, BASE, 4'hF, 32'h0, a, e, d, lat);
    model_dat = ref_mem[0];
    n_cmp++; if (d !== 32'hA5A5_5A5A || a !== 1'b1) begin n_fail++; $display("FAIL oor_readback got=%h ack=%b exp=a5a55a5a ack=1", d, a); end
    do_xfer(1'b0, BASE + (DEPTH - 4) * 4 + 32'h3C, 4'hF, 32'h0, a, e, d, lat);
    n_cmp++; if (d !== model_dat || e !== 1'b1) begin n_fail++; $display("FAIL oor_high_rd got=%h err=%b exp=%h err=1", d, e, model_dat); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] vals [4];
    int ack_cyc[$];
    int c, k, got;
    logic a, e; logic [31:0] d; int lat;
    for (int i = 0; i < 4; i++) vals[i] = $urandom;
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; sel = 4'hF;
    adr = BASE + (DEPTH - 4) * 4; dat_w = vals[0];
    c = 0; k = 0;
    while (k < 4 && c < 20) begin
      @(posedge clk); #1; c++;
      if (ack) begin
        ack_cyc.push_back(c);
        model_write(adr, 4'hF, dat_w);
        k++;
        if (k < 4) begin adr = BASE + (DEPTH - 4 + k) * 4; dat_w = vals[k]; end
        else begin cyc = 1'b0; stb = 1'b0; end
      end
    end
    cyc = 1'b0; stb = 1'b0;
    for (int i = 0; i < 4; i++) begin
      got = (i < ack_cyc.size()) ? ack_cyc[i] : -1;
      n_cmp++; if (got != 2 * i + 1) begin n_fail++; $display("FAIL b2b_ack_cycle%0d got=%0d exp=%0d", i, got, 2 * i + 1); end
    end
    for (int i = 0; i < 4; i++) begin
      do_xfer(1'b0, BASE + (DEPTH - 4 + i) * 4, 4'hF, 32'h0, a, e, d, lat);
      model_dat = ref_mem[DEPTH - 4 + i];
      n_cmp++; if (d !== vals[i] || a !== 1'b1) begin n_fail++; $display("FAIL b2b_readback%0d got=%h ack=%b exp=%h", i, d, a, vals[i]); end
    end
  endtask

  task automatic test_reset_async;
    @(negedge clk); #2;
    rst = 1'b1; #1;
    n_cmp++; if (dat_r !== 32'h0 || ack !== 1'b0 || err !== 1'b0) begin n_fail++; $display("FAIL async_reset dat=%h ack=%b err=%b exp all 0", dat_r, ack, err); end
    @(negedge clk); rst = 1'b0;
    model_dat = 32'h0;
  endtask

  task automatic test_reset_midxfer;
    logic a, e; logic [31:0] d; int lat;
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = BASE + 32'h20; sel = 4'hF; dat_w = 32'h1357_9BDF;
    @(posedge clk); #1;
    n_cmp++; if (ack !== 1'b1) begin n_fail++; $display("FAIL mid_ack_before_rst got=%b exp=1", ack); end
    #2; rst = 1'b1; #1;
    n_cmp++; if (ack !== 1'b0 || err !== 1'b0 || dat_r !== 32'h0) begin n_fail++; $display("FAIL mid_reset ack=%b err=%b dat=%h exp 0 0 0", ack, err, dat_r); end
    @(negedge clk); rst = 1'b0; cyc = 1'b0; stb = 1'b0;
    model_write(BASE + 32'h20, 4'hF, 32'h1357_9BDF);
    model_dat = 32'h0;
    do_xfer(1'b0, BASE + 32'h20, 4'hF, 32'h0, a, e, d, lat);
    model_dat = ref_mem[8];
    n_cmp++; if (d !== 32'h1357_9BDF || a !== 1'b1) begin n_fail++; $display("FAIL mid_write_kept got=%h ack=%b exp=13579bdf", d, a); end
  endtask

  task automatic test_random;
    logic a, e; logic [31:0] d, ad, v, expd; logic [3:0] s; logic w; int lat, r;
    for (int i = 0; i < DEPTH; i++) begin
      v = $urandom;
      do_xfer(1'b1, BASE + i * 4, 4'hF, v, a, e, d, lat);
      model_write(BASE + i * 4, 4'hF, v);
      n_cmp++; if (a !== 1'b1 || e !== 1'b0) begin n_fail++; $display("FAIL preload%0d ack=%b err=%b", i, a, e); end
    end
    for (int i = 0; i < 60; i++) begin
      r = $urandom_range(0, 9);
      w = 1'($urandom_range(0, 1));
      s = 4'($urandom_range(0, 15));
      v = $urandom;
      if (r == 0) ad = LIMIT + 4 * $urandom_range(0, 63);
      else if (r == 1) ad = BASE - 4 * $urandom_range(1, 63);
      else ad = BASE + 4 * $urandom_range(0, DEPTH - 1) + 32'($urandom_range(0, 3));
      if (!model_in_rng(ad)) begin
        do_xfer(w, ad, s, v, a, e, d, lat);
        n_cmp++; if (e !== 1'b1 || a !== 1'b0 || d !== model_dat) begin n_fail++; $display("FAIL rnd_oor%0d adr=%h ack=%b err=%b dat=%h exp_dat=%h", i, ad, a, e, d, model_dat); end
      end else if (w) begin
        do_xfer(1'b1, ad, s, v, a, e, d, lat);
        model_write(ad, s, v);
        n_cmp++; if (a !== 1'b1 || e !== 1'b0 || d !== model_dat) begin n_fail++; $display("FAIL rnd_wr%0d adr=%h ack=%b err=%b dat=%h exp_dat=%h", i, ad, a, e, d, model_dat); end
      end else begin
        exp_q.push_back(ref_mem[model_idx(ad)]);
        do_xfer(1'b0, ad, s, v, a, e, d, lat);
        expd = exp_q.pop_front();
        model_dat = expd;
        n_cmp++; if (a !== 1'b1 || e !== 1'b0 || d !== expd) begin n_fail++; $display("FAIL rnd_rd%0d adr=%h ack=%b err=%b got=%h exp=%h", i, ad, a, e, d, expd); end
      end
    end
  endtask

`ifdef WB_DMEM_PARITY_EN
  task automatic test_parity;
    logic a, e; logic [31:0] d; int lat;
    do_xfer(1'b1, BASE + 32'h14, 4'hF, 32'h0000_0001, a, e, d, lat);
    model_write(BASE + 32'h14, 4'hF, 32'h0000_0001);
    @(negedge clk);
    dut.mem[5][0] = ~dut.mem[5][0];
    ref_mem[5][0] = ~ref_mem[5][0];
    do_xfer(1'b0, BASE + 32'h14, 4'hF, 32'h0, a, e, d, lat);
    n_cmp++; if (e !== 1'b1 || a !== 1'b0) begin n_fail++; $display("FAIL parity_err ack=%b err=%b exp ack=0 err=1", a, e); end
    n_cmp++; if (d !== ref_mem[5]) begin n_fail++; $display("FAIL parity_dat got=%h exp=%h", d, ref_mem[5]); end
    do_xfer(1'b0, BASE + 32'h14, 4'hE, 32'h0, a, e, d, lat);
    n_cmp++; if (a !== 1'b1 || e !== 1'b0) begin n_fail++; $display("FAIL parity_masked ack=%b err=%b exp ack=1 err=0", a, e); end
  endtask
`endif

  initial begin
    test_reset();
    test_word_rw();
    test_byte_lanes();
    test_out_of_range();
    test_back_to_back();
    test_reset_async();
    test_reset_midxfer();
    test_random();
`ifdef WB_DMEM_PARITY_EN
    test_parity();
`endif
    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #400000;
    n_fail++;
    $display("FAIL watchdog sim_time=%0t exp=completion", $time);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
